fetch_decode_ctrl: RTL and testbench

FETCH_DECODE_CTRL -- requirements
Module: fetch_decode_ctrl

---
 rtl/fetch_decode_ctrl_if.sv | 40 ++++
 rtl/fetch_decode_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_fetch_decode_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_ctrl_if.sv
// fetch_decode_ctrl_if
// Bundles the instruction handshake and the decoded control/datapath signals
// of fetch_decode_ctrl.
//   master : the fetch/decode controller (drives instr_ready, pc, fields,
//            selects and strobes; receives instr, instr_valid, Zero)
//   slave  : the instruction source / datapath side
interface fetch_decode_ctrl_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        Zero;
  logic [7:0]  pc;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] SEin;
  logic [3:0]  FuncCode;
  logic        Regsel;
  logic        ALUsel;
  logic        MemToRegSel;
  logic [1:0]  ALUOp;
  logic        MemWrite;
  logic        MemRead;
  logic        RegWrite;
  logic        illegal;

  modport master (
    input  instr, instr_valid, Zero,
    output instr_ready, pc, rs, rt, rd, SEin, FuncCode,
           Regsel, ALUsel, MemToRegSel, ALUOp,
           MemWrite, MemRead, RegWrite, illegal
  );

  modport slave (
    output instr, instr_valid, Zero,
    input  instr_ready, pc, rs, rt, rd, SEin, FuncCode,
           Regsel, ALUsel, MemToRegSel, ALUOp,
           MemWrite, MemRead, RegWrite, illegal
  );
endinterface

// File: rtl/fetch_decode_ctrl.sv
// fetch_decode_ctrl
// Multi-cycle fetch/decode controller for a small MIPS-like datapath.
// Ports:
//   clk    : system clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : fetch_decode_ctrl_if.master (instruction handshake, pc,
//            decoded fields, selects, ALUOp, memory/register strobes, illegal)
// Build option:
//   FETCH_DECODE_CTRL_BRANCH_EN defined -> BEQ supported (conditional pc jump);
//   undefined (default)               -> BEQ opcode treated as unsupported.
//
// state  | meaning
// FETCH  | waiting for instr_valid & instr_ready
// DECODE | fields/selects loaded from the latched instruction
// EXEC   | ALU step; BEQ samples Zero here
// MEM    | MemRead (LW) or MemWrite (SW)
// WB     | RegWrite
//
// Every output is a register loaded from the current state, so each output
// trails the state by one cycle.  instr_ready follows the same rule, and
// acceptance uses the registered instr_ready, never the raw state.
module fetch_decode_ctrl (
  input  logic                       clk,
  input  logic                       rst_n,
  fetch_decode_ctrl_if.master        bus
);

`ifdef FETCH_DECODE_CTRL_BRANCH_EN
  localparam logic BRANCH_EN = 1'b1;
`else
  localparam logic BRANCH_EN = 1'b0;
`endif

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  pc_q, pc_d;
  logic        ready_q, ready_d;
  logic        illegal_q, illegal_d;
  logic [4:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [15:0] sein_q, sein_d;
  logic [3:0]  func_q, func_d;
  logic        regsel_q, regsel_d;
  logic        alusel_q, alusel_d;
  logic        memtoreg_q, memtoreg_d;
  logic [1:0]  aluop_q, aluop_d;
  logic        memwrite_q, memwrite_d;
  logic        memread_q, memread_d;
  logic        regwrite_q, regwrite_d;

  logic [5:0]  op;
  logic        op_legal;
  logic        accept;

  assign op     = instr_q[31:26];
  assign accept = bus.instr_valid & ready_q;

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_R, OP_ADDI, OP_LW, OP_SW: op_legal = 1'b1;
      OP_BEQ:                      op_legal = BRANCH_EN;
      default:                     op_legal = 1'b0;
    endcase
  end

  // state register (and output registers)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      instr_q    <= '0;
      pc_q       <= '0;
      ready_q    <= 1'b1;
      illegal_q  <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      sein_q     <= '0;
      func_q     <= '0;
      regsel_q   <= 1'b0;
      alusel_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      aluop_q    <= '0;
      memwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      regwrite_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      ready_q    <= ready_d;
      illegal_q  <= illegal_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      sein_q     <= sein_d;
      func_q     <= func_d;
      regsel_q   <= regsel_d;
      alusel_q   <= alusel_d;
      memtoreg_q <= memtoreg_d;
      aluop_q    <= aluop_d;
      memwrite_q <= memwrite_d;
      memread_q  <= memread_d;
      regwrite_q <= regwrite_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (accept) state_d = S_DECODE;
      S_DECODE: state_d = op_legal ? S_EXEC : S_FETCH;
      S_EXEC: begin
        case (op)
          OP_R, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:  state_d = S_MEM;
          default:       state_d = S_FETCH;
        endcase
      end
      S_MEM:    state_d = (op == OP_LW) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // output logic
  always_comb begin
    instr_d    = accept ? bus.instr : instr_q;
    ready_d    = (state_q == S_FETCH) && !accept;
    pc_d       = pc_q;
    illegal_d  = illegal_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    sein_d     = sein_q;
    func_d     = func_q;
    regsel_d   = regsel_q;
    alusel_d   = alusel_q;
    memtoreg_d = memtoreg_q;
    aluop_d    = aluop_q;
    memwrite_d = 1'b0;
    memread_d  = 1'b0;
    regwrite_d = 1'b0;

    if (accept) pc_d = pc_q + 8'd1;

    case (state_q)
      S_DECODE: begin
        rs_d       = instr_q[25:21];
        rt_d       = instr_q[20:16];
        rd_d       = instr_q[15:11];
        sein_d     = instr_q[15:0];
        func_d     = instr_q[3:0];
        regsel_d   = 1'b0;
        alusel_d   = 1'b0;
        memtoreg_d = 1'b0;
        aluop_d    = 2'b00;
        case (op)
          OP_R: begin
            regsel_d = 1'b1;
            aluop_d  = 2'b10;
          end
          OP_ADDI, OP_SW: alusel_d = 1'b1;
          OP_LW: begin
            alusel_d   = 1'b1;
            memtoreg_d = 1'b1;
          end
          OP_BEQ: aluop_d = BRANCH_EN ? 2'b01 : 2'b00;
          default: ;
        endcase
        if (!op_legal) illegal_d = 1'b1;
      end
      S_EXEC: begin
        // pc already holds the incremented value; the offset is added on top
        if (BRANCH_EN && (op == OP_BEQ) && bus.Zero)
          pc_d = pc_q + instr_q[7:0];
      end
      S_MEM: begin
        memread_d  = (op == OP_LW);
        memwrite_d = (op == OP_SW);
      end
      S_WB:    regwrite_d = 1'b1;
      default: ;
    endcase
  end

  assign bus.instr_ready = ready_q;
  assign bus.pc          = pc_q;
  assign bus.rs          = rs_q;
  assign bus.rt          = rt_q;
  assign bus.rd          = rd_q;
  assign bus.SEin        = sein_q;
  assign bus.FuncCode    = func_q;
  assign bus.Regsel      = regsel_q;
  assign bus.ALUsel      = alusel_q;
  assign bus.MemToRegSel = memtoreg_q;
  assign bus.ALUOp       = aluop_q;
  assign bus.MemWrite    = memwrite_q;
  assign bus.MemRead     = memread_q;
  assign bus.RegWrite    = regwrite_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// tb_fetch_decode_ctrl
// Randomized plus directed bench for fetch_decode_ctrl.  The reference model
// describes each instruction as the list of states it visits and derives
// strobe timing, ready timing, pc and illegal from that list.
module tb_fetch_decode_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_decode_ctrl_if bus ();

  fetch_decode_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] pc_m;
  logic       ill_m;

`ifdef FETCH_DECODE_CTRL_BRANCH_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit supported(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h08) || (op == 6'h23) || (op == 6'h2B) ||
           ((op == 6'h04) && BR);
  endfunction

  task automatic check_reset_outputs();
    check("rst_ready",  bus.instr_ready, 1);
    check("rst_pc",     bus.pc, 0);
    check("rst_illegal",bus.illegal, 0);
    check("rst_regwr",  bus.RegWrite, 0);
    check("rst_memrd",  bus.MemRead, 0);
    check("rst_memwr",  bus.MemWrite, 0);
    check("rst_fields", {bus.rs, bus.rt, bus.rd, bus.FuncCode}, 0);
    check("rst_sein",   bus.SEin, 0);
    check("rst_sels",   {bus.Regsel, bus.ALUsel, bus.MemToRegSel, bus.ALUOp}, 0);
  endtask

  // Called #1 after a rising edge; leaves the bench #1 after a rising edge.
  task automatic reset_dut();
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    #1;
    check_reset_outputs();
    pc_m  = 8'd0;
    ill_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", bus.instr_ready, 1);
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic z);
    string      path[$];
    string      st;
    logic [5:0] op;
    int         last;
    logic [31:0] junk;
    op = ins[31:26];
    path.push_back("DECODE");
    if (supported(op)) path.push_back("EXEC");
    if (op == 6'h23 || op == 6'h2B) path.push_back("MEM");
    if (op == 6'h00 || op == 6'h08 || op == 6'h23) path.push_back("WB");
    last = path.size() + 1;

    check("ready_before", bus.instr_ready, 1);
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    bus.Zero = z;
    @(posedge clk); #1;
    pc_m = pc_m + 8'd1;
    if (!supported(op)) ill_m = 1'b1;
    if (op == 6'h04 && supported(op) && z) pc_m = pc_m + ins[7:0];

    for (int k = 1; k <= last; k++) begin
      junk = $urandom;
      bus.instr = junk;
      bus.instr_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      st = (k - 1 < path.size()) ? path[k - 1] : "FETCH";
      check("regwrite", bus.RegWrite, st == "WB");
      check("memread",  bus.MemRead,  (st == "MEM") && (op == 6'h23));
      check("memwrite", bus.MemWrite, (st == "MEM") && (op == 6'h2B));
      check("ready",    bus.instr_ready, k == last);
      if (op == 6'h23 && st == "WB") check("memtoreg_wb", bus.MemToRegSel, 1);
    end
    bus.instr_valid = 1'b0;

    check("pc", bus.pc, pc_m);
    check("illegal", bus.illegal, ill_m);
    if (supported(op)) begin
      check("rs", bus.rs, ins[25:21]);
      check("rt", bus.rt, ins[20:16]);
      check("rd", bus.rd, ins[15:11]);
      check("SEin", bus.SEin, ins[15:0]);
      check("FuncCode", bus.FuncCode, ins[3:0]);
      case (op)
        6'h00: check("sels_r",    {bus.Regsel, bus.ALUsel, bus.ALUOp, bus.MemToRegSel}, 5'b1_0_10_0);
        6'h08: check("sels_addi", {bus.Regsel, bus.ALUsel, bus.ALUOp, bus.MemToRegSel}, 5'b0_1_00_0);
        6'h23: check("sels_lw",   {bus.Regsel, bus.ALUsel, bus.ALUOp, bus.MemToRegSel}, 5'b0_1_00_1);
        6'h2B: check("sels_sw",   {bus.ALUsel, bus.ALUOp}, 3'b1_00);
        default: check("sels_beq", {bus.ALUsel, bus.ALUOp}, 3'b0_01);
      endcase
    end
  endtask

  task automatic beq_from_pc5(input logic z);
    for (int i = 0; i < 5; i++) run_instr(32'h00221820, 1'b0);
    check("pc_is_5", bus.pc, 5);
    run_instr(32'h10000003, z);
  endtask

  initial begin
    logic [5:0]  ops [6];
    logic [31:0] r;
    ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h23;
    ops[3] = 6'h2B; ops[4] = 6'h04; ops[5] = 6'h3F;

    bus.instr = '0;
    bus.instr_valid = 1'b0;
    bus.Zero = 1'b0;
    rst_n = 1'b0;
    pc_m = 8'd0;
    ill_m = 1'b0;
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_instr(32'h00221820, 1'b0);
    run_instr(32'h8C410028, 1'b0);
    run_instr(32'hAC410014, 1'b0);

    @(posedge clk); #1;
    reset_dut();
    beq_from_pc5(1'b1);
    check("beq_taken_pc", bus.pc, BR ? 9 : 6);
    check("beq_taken_illegal", bus.illegal, BR ? 0 : 1);
    reset_dut();
    beq_from_pc5(1'b0);
    check("beq_not_taken_pc", bus.pc, 6);

    reset_dut();
    run_instr(32'hFC000000, 1'b0);
    check("illegal_set", bus.illegal, 1);
    run_instr(32'h20010005, 1'b0);
    run_instr(32'h00221820, 1'b0);
    check("illegal_sticky", bus.illegal, 1);

    // reset while an LW sits in EXEC
    reset_dut();
    bus.instr = 32'h8C410028;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    reset_dut();
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("no_memread_after_rst", bus.MemRead, 0);
      check("no_regwrite_after_rst", bus.RegWrite, 0);
      check("idle_ready", bus.instr_ready, 1);
    end
    check("idle_pc", bus.pc, 0);

    for (int n = 0; n < 40; n++) begin
      r = $urandom;
      r[31:26] = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) r[31:26] = 6'($urandom);
      run_instr(r, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule
